// File: rtl/sb_cfg_pkg.sv
// Shared constants and state encoding for the switch box configuration loader.
package sb_cfg_pkg;

  localparam logic [7:0] SYNC_WORD   = 8'hA5;

  localparam logic [2:0] SIDE_NONE   = 3'd0;
  localparam logic [2:0] SIDE_TOP    = 3'd1;
  localparam logic [2:0] SIDE_RIGHT  = 3'd2;
  localparam logic [2:0] SIDE_BOTTOM = 3'd3;
  localparam logic [2:0] SIDE_LEFT   = 3'd4;

  localparam int NWORDS = 18;

  typedef enum logic [1:0] {
    SYNC,
    LOAD,
    CSUM,
    CHECK
  } cfg_state_e;

endpackage

// File: rtl/sb_cfg_word_check.sv
// Combinational legality check of one routing word: [2:0] side code, [CW-1:3] pin index.
module sb_cfg_word_check
  import sb_cfg_pkg::*;
#(
  parameter int NTB = 5,
  parameter int NLR = 4,
  parameter int CW  = 6
) (
  input  logic [CW-1:0] word,
  output logic          ok
);

  logic [2:0]    side;
  logic [CW-4:0] idx;

  assign side = word[2:0];
  assign idx  = word[CW-1:3];

  always_comb begin
    ok = 1'b0;
    case (side)
      SIDE_NONE:              ok = 1'b1;
      SIDE_TOP, SIDE_BOTTOM:  ok = (32'(idx) < NTB);
      SIDE_RIGHT, SIDE_LEFT:  ok = (32'(idx) < NLR);
      default:                ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/switchbox_cfg_loader.sv
// Serial frame loader for one switch box tile; words commit atomically after a legality check.
// Optional frame checksum enabled by defining SB_CFG_CHECKSUM_EN.
//
// state | meaning
// SYNC  | hunting for the 0xA5 sync byte
// LOAD  | shifting routing words into the shadow array
// CSUM  | collecting the 8-bit checksum (checksum build only)
// CHECK | one cycle legality decision, commit or reject
module switchbox_cfg_loader
  import sb_cfg_pkg::*;
#(
  parameter int NTB = 5,
  parameter int NLR = 4,
  parameter int CW  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_bit,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic [NTB*CW-1:0] dtop,
  output logic [NTB*CW-1:0] dbottom,
  output logic [NLR*CW-1:0] dleft,
  output logic [NLR*CW-1:0] dright
);

  cfg_state_e    state_q, state_d;
  logic [7:0]    sync_q;
  logic [7:0]    sync_next;
  logic [2:0]    bcnt_q;
  logic [4:0]    wcnt_q;
  logic [CW-1:0] shadow [NWORDS];
  logic [NWORDS-1:0] word_ok;
  logic          frame_ok;
  logic          acc;
  logic          last_load_bit;
  logic          commit;
  logic          reject;

  assign acc           = cfg_valid && cfg_ready;
  assign sync_next     = {cfg_bit, sync_q[7:1]};
  assign last_load_bit = (bcnt_q == 3'(CW-1)) && (wcnt_q == 5'(NWORDS-1));
  assign cfg_ready     = !rst && (state_q != CHECK);

  for (genvar g = 0; g < NWORDS; g++) begin : g_chk
    sb_cfg_word_check #(.NTB(NTB), .NLR(NLR), .CW(CW)) u_chk (
      .word (shadow[g]),
      .ok   (word_ok[g])
    );
  end

`ifdef SB_CFG_CHECKSUM_EN
  logic [7:0] csum_q;
  logic [7:0] sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < NWORDS; i++) sum = sum + 8'(shadow[i]);
  end

  assign frame_ok = (&word_ok) && (sum == csum_q);
`else
  assign frame_ok = &word_ok;
`endif

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    reject  = 1'b0;
    case (state_q)
      SYNC: if (acc && (sync_next == SYNC_WORD)) state_d = LOAD;
      LOAD: if (acc && last_load_bit) begin
`ifdef SB_CFG_CHECKSUM_EN
        state_d = CSUM;
`else
        state_d = CHECK;
`endif
      end
      CSUM: if (acc && (bcnt_q == 3'd7)) state_d = CHECK;
      CHECK: begin
        state_d = SYNC;
        commit  = frame_ok;
        reject  = !frame_ok;
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SYNC;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      bcnt_q   <= '0;
      wcnt_q   <= '0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      dtop     <= '0;
      dbottom  <= '0;
      dleft    <= '0;
      dright   <= '0;
      for (int i = 0; i < NWORDS; i++) shadow[i] <= '0;
`ifdef SB_CFG_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      cfg_done <= commit;
      cfg_err  <= reject;
      case (state_q)
        SYNC: if (acc) sync_q <= sync_next;
        LOAD: if (acc) begin
          shadow[wcnt_q][bcnt_q] <= cfg_bit;
          if (bcnt_q == 3'(CW-1)) begin
            bcnt_q <= '0;
            wcnt_q <= (wcnt_q == 5'(NWORDS-1)) ? 5'd0 : wcnt_q + 5'd1;
          end else begin
            bcnt_q <= bcnt_q + 3'd1;
          end
        end
`ifdef SB_CFG_CHECKSUM_EN
        CSUM: if (acc) begin
          csum_q <= {cfg_bit, csum_q[7:1]};
          bcnt_q <= bcnt_q + 3'd1;
        end
`endif
        CHECK: begin
          // Clearing here gives every new frame a clean sync hunt.
          sync_q <= '0;
          bcnt_q <= '0;
          wcnt_q <= '0;
          if (commit) begin
            for (int i = 0; i < NTB; i++) begin
              dtop[i*CW +: CW]    <= shadow[i];
              dbottom[i*CW +: CW] <= shadow[NTB+i];
            end
            for (int i = 0; i < NLR; i++) begin
              dleft[i*CW +: CW]   <= shadow[2*NTB+i];
              dright[i*CW +: CW]  <= shadow[2*NTB+NLR+i];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_switchbox_cfg_loader.sv
// Directed plus randomized bench for switchbox_cfg_loader against a word-level reference model.
module tb_switchbox_cfg_loader;

  localparam int NTB = 5;
  localparam int NLR = 4;
  localparam int CW  = 6;
  localparam int NW  = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_bit = 1'b0;
  logic cfg_valid = 1'b0;
  logic cfg_ready, cfg_done, cfg_err;
  logic [NTB*CW-1:0] dtop, dbottom;
  logic [NLR*CW-1:0] dleft, dright;

  int n_tests = 0;
  int n_fail  = 0;
  int fw [NW];   // frame words about to be sent
  int cm [NW];   // words the switch matrix should currently see

  always #5 clk = ~clk;

  switchbox_cfg_loader #(.NTB(NTB), .NLR(NLR), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_bit   (cfg_bit),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .dtop      (dtop),
    .dbottom   (dbottom),
    .dleft     (dleft),
    .dright    (dright)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic bit word_legal(input int w);
    int side = w % 8;
    int idx  = w / 8;
    case (side)
      0:       return 1'b1;
      1, 3:    return idx < NTB;
      2, 4:    return idx < NLR;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int frame_sum();
    int s = 0;
    for (int i = 0; i < NW; i++) s += fw[i];
    return s % 256;
  endfunction

  function automatic logic [63:0] pack(input int base, input int n);
    logic [63:0] r = '0;
    for (int i = 0; i < n; i++) r |= 64'(cm[base+i]) << (i*CW);
    return r;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_dtop"},    64'(dtop),    pack(0, NTB));
    chk({tag, "_dbottom"}, 64'(dbottom), pack(NTB, NTB));
    chk({tag, "_dleft"},   64'(dleft),   pack(2*NTB, NLR));
    chk({tag, "_dright"},  64'(dright),  pack(2*NTB+NLR, NLR));
  endtask

  task automatic send_bit(input bit b, input bit gaps);
    int guard;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        cfg_valid = 1'b0;
      end
    end
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_bit   = b;
    guard = 0;
    while (!cfg_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("ready_timeout", 64'(cfg_ready), 64'd1);
    @(posedge clk);
  endtask

  task automatic send_sync(input bit gaps);
    for (int k = 0; k < 8; k++) send_bit(bit'((8'hA5 >> k) & 1), gaps);
  endtask

  task automatic send_frame(input int csum, input bit garbage, input bit gaps, input string tag);
    bit legal;
    if (garbage) begin
      send_bit(1'b1, gaps);
      send_bit(1'b1, gaps);
      send_bit(1'b0, gaps);
    end
    send_sync(gaps);
    for (int w = 0; w < NW; w++)
      for (int k = 0; k < CW; k++) send_bit(bit'((fw[w] >> k) & 1), gaps);
`ifdef SB_CFG_CHECKSUM_EN
    for (int k = 0; k < 8; k++) send_bit(bit'((csum >> k) & 1), gaps);
`endif
    legal = 1'b1;
    for (int w = 0; w < NW; w++) if (!word_legal(fw[w])) legal = 1'b0;
`ifdef SB_CFG_CHECKSUM_EN
    if (csum != frame_sum()) legal = 1'b0;
`endif
    // cycle E+1: decision cycle, nothing visible yet
    @(negedge clk);
    cfg_valid = 1'b0;
    chk({tag, "_check_ready"}, 64'(cfg_ready), 64'd0);
    chk({tag, "_check_done"},  64'(cfg_done),  64'd0);
    chk({tag, "_check_err"},   64'(cfg_err),   64'd0);
    check_outputs({tag, "_pre"});
    if (legal) for (int w = 0; w < NW; w++) cm[w] = fw[w];
    // after edge E+2
    @(negedge clk);
    chk({tag, "_done"}, 64'(cfg_done), 64'(legal));
    chk({tag, "_err"},  64'(cfg_err),  64'(!legal));
    check_outputs({tag, "_post"});
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(cfg_done),  64'd0);
    chk({tag, "_err_pulse"},  64'(cfg_err),   64'd0);
    chk({tag, "_ready_back"}, 64'(cfg_ready), 64'd1);
  endtask

  task automatic clear_fw();
    for (int w = 0; w < NW; w++) fw[w] = 0;
  endtask

  function automatic int rand_word();
    int side, idx;
    if ($urandom_range(0, 99) < 4) return int'($urandom_range(0, 63));
    side = int'($urandom_range(0, 4));
    case (side)
      1, 3:    idx = int'($urandom_range(0, NTB-1));
      2, 4:    idx = int'($urandom_range(0, NLR-1));
      default: idx = int'($urandom_range(0, 7));
    endcase
    return idx * 8 + side;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cs;
    for (int w = 0; w < NW; w++) cm[w] = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(cfg_ready), 64'd0);
    chk("reset_done",  64'(cfg_done),  64'd0);
    chk("reset_err",   64'(cfg_err),   64'd0);
    check_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("release_ready", 64'(cfg_ready), 64'd1);

    clear_fw();
    fw[0] = 'h0B;
    fw[17] = 'h21;
    send_frame('h2C, 1'b1, 1'b0, "legal");
    chk("legal_dtop_w0",   64'(dtop[5:0]),     64'h0B);
    chk("legal_dright_w3", 64'(dright[23:18]), 64'h21);

    clear_fw();
    fw[10] = 'h22;
    send_frame('h22, 1'b0, 1'b0, "illegal_idx");
    chk("illegal_keeps_dtop", 64'(dtop[5:0]), 64'h0B);

    clear_fw();
`ifdef SB_CFG_CHECKSUM_EN
    send_frame('h01, 1'b0, 1'b0, "bad_csum");
    chk("bad_csum_keeps_dright", 64'(dright[23:18]), 64'h21);
`else
    send_frame('h00, 1'b0, 1'b0, "zero_frame");
    chk("zero_frame_dtop", 64'(dtop), 64'h0);
`endif

    clear_fw();
    fw[0] = 'h0B;
    fw[17] = 'h21;
    send_frame('h2C, 1'b0, 1'b0, "reload");

    // reset after 50 load bits: partial frame discarded, outputs cleared
    send_sync(1'b0);
    for (int k = 0; k < 50; k++) send_bit(bit'($urandom_range(0, 1)), 1'b0);
    @(negedge clk);
    cfg_valid = 1'b0;
    rst = 1'b1;
    #1;
    for (int w = 0; w < NW; w++) cm[w] = 0;
    check_outputs("midreset");
    chk("midreset_ready", 64'(cfg_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_release_ready", 64'(cfg_ready), 64'd1);
    clear_fw();
    fw[9] = 'h19;
    send_frame('h19, 1'b0, 1'b0, "after_reset");
    chk("after_reset_bottom4", 64'(dbottom[29:24]), 64'h19);

    clear_fw();
    fw[0] = 'h0B;
    fw[17] = 'h21;
    send_frame('h2C, 1'b1, 1'b1, "gaps");
    chk("gaps_dtop_w0",   64'(dtop[5:0]),     64'h0B);
    chk("gaps_dright_w3", 64'(dright[23:18]), 64'h21);

    for (int f = 0; f < 16; f++) begin
      for (int w = 0; w < NW; w++) fw[w] = rand_word();
      cs = frame_sum();
      if ($urandom_range(0, 9) == 0) cs = (cs + 1) % 256;
      send_frame(cs, 1'b0, bit'($urandom_range(0, 1)), $sformatf("rand%0d", f));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/switchbox_cfg_loader.md
# switchbox_cfg_loader

Serial configuration loader for one 5×4 switch box tile. It deserialises a framed bitstream and checks every routing word for legality. It produces the 18 six-bit routing words (5 top, 5 bottom, 4 left, 4 right) that the switch matrix consumes, and commits them atomically only when the whole frame is valid.

## Interface
- `NTB`, default 5: pins per top/bottom side.
- `NLR`, default 4: pins per left/right side.
- `CW`, default 6: routing word width; [2:0] is the side code, [5:3] is the pin index.
- `clk` input, 1 bit: single clock; all state is clocked on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `cfg_bit` input, 1 bit: serial configuration data.
- `cfg_valid` input, 1 bit: `cfg_bit` is valid this cycle.
- `cfg_ready` output, 1 bit: the loader accepts a bit this cycle.
- `cfg_done` output, 1 bit: one-cycle pulse when a frame has been committed.
- `cfg_err` output, 1 bit: one-cycle pulse when a frame is rejected.
- `dtop` output, NTB*CW bits: top words; word i is at [i*CW +: CW].
- `dbottom` output, NTB*CW bits: bottom words, same packing.
- `dleft` output, NLR*CW bits: left words, same packing.
- `dright` output, NLR*CW bits: right words, same packing.

## Operation
- A bit is accepted when `cfg_valid && cfg_ready`. All fields are sent LSB first.
- Frame layout:
  - 8-bit sync, 0xA5.
  - 18 words in order top0..4, bottom0..4, left0..3, right0..3.
  - Optional 8-bit checksum (see Configuration).
- State SYNC:
  - Accepted bits enter an 8-bit shift register at the MSB.
  - When the register equals 0xA5, go to LOAD.
  - The shift register is cleared on entry to SYNC.
- State LOAD:
  - Accepted bits go into the shadow words.
  - A 3-bit bit counter and a 5-bit word counter track position.
  - After bit 107 go to CSUM if checksum is enabled, otherwise to CHECK.
- State CSUM: collects 8 bits, then goes to CHECK.
- State CHECK (one cycle, `cfg_ready`=0): the frame is legal only if every word is legal.
  - Side code 0 means disconnected; it is legal with any index.
  - Side codes 1 (top) and 3 (bottom) require index < NTB.
  - Side codes 2 (right) and 4 (left) require index < NLR.
  - Side codes 5–7 are illegal.
  - If checksum is enabled, the checksum must also match.
- Legal frame: at the next edge copy shadow to outputs, pulse `cfg_done`, and go to SYNC.
- Illegal frame: outputs are unchanged, pulse `cfg_err`, and go to SYNC.
- `cfg_done` and `cfg_err` are never high together.
- Outputs change only on commit. Partial frames are never visible.
- Reset:
  - All outputs go to 0, which is every pin disconnected.
  - Shadow words, counters and the shift register are cleared.
  - The state returns to SYNC.
  - A reset mid-frame discards the partial frame; a complete new frame, including sync, is then required.

## Timing
- `cfg_ready` is 1 in SYNC, LOAD and CSUM, and 0 in CHECK. It is 0 while `rst` is high.
- The last frame bit is accepted at edge E. The FSM is in CHECK during cycle E+1.
- Outputs and the `cfg_done`/`cfg_err` pulse are registered at edge E+2 and stay high for one cycle.
- Earliest next sync bit is accepted in the cycle after E+2.
- Throughput: 1 bit/cycle. Gaps in `cfg_valid` stall without loss.
- Reset values: `cfg_ready`=0 during reset, `cfg_done`=0, `cfg_err`=0, all word outputs 0.

## Configuration
- `SB_CFG_CHECKSUM_EN` defined:
  - The frame carries an 8-bit checksum: the sum modulo 256 of the 18 words, zero-extended.
  - A mismatch rejects the frame.
  - Frame length is 124 bits.
- Undefined: no CSUM state, frame length is 116 bits, and only legality is checked.

## Structure
- Package `sb_cfg_pkg` holds:
  - `SYNC_WORD`=8'hA5.
  - Side code constants `SIDE_NONE`/`SIDE_TOP`/`SIDE_RIGHT`/`SIDE_BOTTOM`/`SIDE_LEFT` = 0..4.
  - `NWORDS`=18.
  - State enum SYNC/LOAD/CSUM/CHECK.
- Sub-module `sb_cfg_word_check`: combinational legality check of one CW-bit word. It takes NTB/NLR parameters and is instantiated 18 times.

## Test plan
- **Reset:** assert `rst` mid-run → all word outputs 0, `cfg_ready`=0; release → `cfg_ready`=1 on the next cycle.
- **Legal frame:** garbage bits 1,1,0 then 0xA5, then top0=0x0B, right3=0x21, others 0, checksum 0x2C → `cfg_done` pulses at E+2; `dtop`[5:0]=0x0B, `dright`[23:18]=0x21, all else 0.
- **Illegal index:** left0=0x22 (right side, index 4), checksum 0x22 → `cfg_err` pulses; outputs keep the previous frame's values.
- **Bad checksum** (macro on): all-zero words, checksum 0x01 → `cfg_err`, outputs unchanged. With the macro off, a 116-bit all-zero frame → `cfg_done`.
- **Mid-frame reset:** assert `rst` after 50 LOAD bits, then send a full frame with bottom4=0x19 → commit with `dbottom`[29:24]=0x19, no residue from the aborted frame.
- **Valid gaps:** random `cfg_valid` deassertion across a legal frame → identical result to the gap-free case; `cfg_done` occurs 2 edges after the last accepted bit.
